// File: rtl/execute_result_stage.sv
// EX->MEM result stage: captures the ALU result and memory/writeback controls,
// presents them to the memory stage over valid/ready, and drives the EX/MEM
// forwarding bus. A two-entry skid buffer keeps in_ready a function of
// registered state only, so memory-stage backpressure never reaches execute
// combinationally.
module execute_result_stage #(
    parameter int XLEN     = 64,
    parameter int REG_ADDR = 5,
    parameter int FUNCT3   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_alu_result,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [REG_ADDR-1:0] in_rd,
    input  logic                in_reg_write,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [FUNCT3-1:0]   in_funct3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_alu_result,
    output logic [XLEN-1:0]     out_store_data,
    output logic [REG_ADDR-1:0] out_rd,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [FUNCT3-1:0]   out_funct3,
    output logic                fwd_valid,
    output logic [REG_ADDR-1:0] fwd_rd,
    output logic [XLEN-1:0]     fwd_data
);

    typedef struct packed {
        logic [XLEN-1:0]     alu_result;
        logic [XLEN-1:0]     store_data;
        logic [REG_ADDR-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [FUNCT3-1:0]   funct3;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // x0 is hardwired to zero, so a write to it must never reach writeback
    // or the forwarding network.
    function automatic entry_t capture_entry(input entry_t raw);
        entry_t e;
        e           = raw;
        e.reg_write = raw.reg_write & (raw.rd != {REG_ADDR{1'b0}});
        return e;
    endfunction

    // An invalid main entry must not advertise any side-effecting control.
    function automatic entry_t clear_ctrl(input entry_t raw);
        entry_t e;
        e           = raw;
        e.reg_write = 1'b0;
        e.mem_read  = 1'b0;
        e.mem_write = 1'b0;
        return e;
    endfunction

    state_t state_r;
    state_t state_next_s;
    entry_t main_r;
    entry_t main_next_s;
    entry_t skid_r;
    entry_t skid_next_s;
    entry_t in_entry_s;
    logic   in_fire_s;
    logic   out_fire_s;

    assign in_ready   = (state_r != ST_TWO);
    assign out_valid  = (state_r != ST_EMPTY);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    assign in_entry_s = capture_entry('{
        alu_result: in_alu_result,
        store_data: in_store_data,
        rd:         in_rd,
        reg_write:  in_reg_write,
        mem_read:   in_mem_read,
        mem_write:  in_mem_write,
        funct3:     in_funct3
    });

    // Next-state and next-storage selection for the EMPTY/ONE/TWO buffer.
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    main_next_s  = in_entry_s;
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_next_s  = in_entry_s;
                    state_next_s = ST_ONE;
                end else if (in_fire_s) begin
                    skid_next_s  = in_entry_s;
                    state_next_s = ST_TWO;
                end else if (out_fire_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (out_fire_s) begin
                    main_next_s  = skid_r;
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_TWO;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase

        // A redirect squashes everything, including an entry offered this cycle.
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            state_next_s = state_next_s;
        end

        // Leaving the main register invalid also drops its controls so the
        // out_* control bits read 0 whenever out_valid is low.
        if (state_next_s == ST_EMPTY) begin
            main_next_s = clear_ctrl(main_next_s);
        end else begin
            main_next_s = main_next_s;
        end
    end

    // State and storage registers; reset also clears all held data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            main_r  <= entry_t'({ENTRY_W{1'b0}});
            skid_r  <= entry_t'({ENTRY_W{1'b0}});
        end else begin
            state_r <= state_next_s;
            main_r  <= main_next_s;
            skid_r  <= skid_next_s;
        end
    end

    assign out_alu_result = main_r.alu_result;
    assign out_store_data = main_r.store_data;
    assign out_rd         = main_r.rd;
    assign out_reg_write  = main_r.reg_write;
    assign out_mem_read   = main_r.mem_read;
    assign out_mem_write  = main_r.mem_write;
    assign out_funct3     = main_r.funct3;

    // Loads are not forwardable here: their data only exists after memory.
    assign fwd_valid = out_valid & main_r.reg_write & ~main_r.mem_read;
    assign fwd_rd    = main_r.rd;
    assign fwd_data  = main_r.alu_result;

endmodule

// File: tb/tb_execute_result_stage.sv
// Self-checking bench for execute_result_stage: directed scenario tasks plus a
// scoreboard monitor that checks every entry the memory stage consumes.
module tb_execute_result_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_alu_result;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_funct3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;

    typedef struct packed {
        logic [63:0] alu_result;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
    } entry_t;

    entry_t sb_q[$];
    entry_t mon_exp;
    entry_t mon_got;
    int     checks = 0;
    int     errors = 0;

    execute_result_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_funct3(out_funct3),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pop/compare on each consumed output, then push accepted inputs.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got out_alu_result=%h, required no output", out_alu_result);
            end else begin
                mon_exp = sb_q.pop_front();
                mon_got = '{out_alu_result, out_store_data, out_rd, out_reg_write,
                            out_mem_read, out_mem_write, out_funct3};
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_entry: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
        if (!out_valid) begin
            checks++;
            if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b000) begin
                errors++;
                $display("FAIL idle_ctrl: got %b, required 000",
                         {out_reg_write, out_mem_read, out_mem_write});
            end
        end
        if (reset || flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back('{in_alu_result, in_store_data, in_rd,
                             in_reg_write & (in_rd != 5'd0),
                             in_mem_read, in_mem_write, in_funct3});
        end
    end

    task automatic drive_entry(input logic [63:0] res, input logic [63:0] sd,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic [2:0] f3);
        in_valid      = 1'b1;
        in_alu_result = res;
        in_store_data = sd;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_funct3     = f3;
    endtask

    task automatic drive_idle();
        in_valid      = 1'b0;
        in_alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        in_rd         = 5'd31;
        in_reg_write  = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_alu_result, out_store_data, out_rd, out_reg_write,
             out_mem_read, out_mem_write, out_funct3, fwd_valid, fwd_rd, fwd_data}
            !== {1'b0, 1'b1, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b res=%h rd=%0d fwd=%b, required 0 1 0 0 0",
                     out_valid, in_ready, out_alu_result, out_rd, fwd_valid);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_entry(64'h0000_0000_0000_002A, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd3);
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({out_valid, out_alu_result, fwd_valid, fwd_rd, fwd_data}
            !== {1'b1, 64'h2A, 1'b1, 5'd5, 64'h2A}) begin
            errors++;
            $display("FAIL basic: got valid=%b res=%h fwd_valid=%b fwd_rd=%0d, required 1 2a 1 5",
                     out_valid, out_alu_result, fwd_valid, fwd_rd);
        end
        next_cycle();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive_entry(64'(i + 1), 64'd0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
            else       drive_idle();
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b, required 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if ({out_valid, out_alu_result} !== {1'b1, 64'(i)}) begin
                    errors++;
                    $display("FAIL stream_out[%0d]: got valid=%b res=%h, required 1 %h",
                             i, out_valid, out_alu_result, 64'(i));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive_entry(64'h11, 64'd0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_entry(64'h22, 64'd0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_alu_result} !== {1'b0, 1'b1, 64'h11}) begin
                errors++;
                $display("FAIL skid_hold[%0d]: got ready=%b valid=%b res=%h, required 0 1 11",
                         i, in_ready, out_valid, out_alu_result);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_alu_result} !== {1'b1, 1'b1, 64'h22}) begin
            errors++;
            $display("FAIL skid_second: got ready=%b valid=%b res=%h, required 1 1 22",
                     in_ready, out_valid, out_alu_result);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_drained: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_rd_zero();
        out_ready = 1'b1;
        drive_entry(64'hFF, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({out_valid, out_alu_result, out_reg_write, fwd_valid} !== {1'b1, 64'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rd_zero: got valid=%b res=%h rw=%b fwd=%b, required 1 ff 0 0",
                     out_valid, out_alu_result, out_reg_write, fwd_valid);
        end
        next_cycle();
    endtask

    task automatic test_load_store();
        out_ready = 1'b1;
        drive_entry(64'h100, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010);
        next_cycle();
        drive_entry(64'h200, 64'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b011);
        @(negedge clk);
        checks++;
        if ({fwd_valid, out_mem_read, out_reg_write, out_rd} !== {1'b0, 1'b1, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL load_fwd: got fwd=%b mr=%b rw=%b rd=%0d, required 0 1 1 7",
                     fwd_valid, out_mem_read, out_reg_write, out_rd);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({out_store_data, out_mem_write, out_alu_result, out_funct3}
            !== {64'hDEAD, 1'b1, 64'h200, 3'b011}) begin
            errors++;
            $display("FAIL store_data: got sd=%h mw=%b res=%h f3=%0d, required dead 1 200 3",
                     out_store_data, out_mem_write, out_alu_result, out_funct3);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        // Flush while TWO with an entry offered.
        out_ready = 1'b0;
        drive_entry(64'h33, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_entry(64'h44, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_entry(64'h55, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL flush_two[%0d]: got valid=%b ready=%b, required 0 1", i, out_valid, in_ready);
            end
            next_cycle();
        end
        // Flush while ONE overrides an in_fire in the same cycle.
        out_ready = 1'b0;
        drive_entry(64'h66, 64'd0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
        next_cycle();
        drive_entry(64'h77, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        drive_idle();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_one: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic accepted;
        int   tmo;
        for (int i = 0; i < 24; i++) begin
            drive_entry({$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            out_ready = 1'($urandom_range(0, 1));
            tmo = 0;
            do begin
                @(negedge clk);
                accepted = in_ready;
                next_cycle();
                out_ready = 1'($urandom_range(0, 1));
                tmo++;
            end while (!accepted && tmo < 50);
            checks++;
            if (!accepted) begin
                errors++;
                $display("FAIL b2b_accept[%0d]: got no in_ready in 50 cycles, required acceptance", i);
            end
        end
        drive_idle();
        out_ready = 1'b1;
        tmo = 0;
        while ((sb_q.size() != 0 || out_valid) && tmo < 50) begin
            next_cycle();
            tmo++;
        end
        checks++;
        if (sb_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL b2b_drain: got %0d entries pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_entry(64'h88, 64'h1234, 5'd3, 1'b1, 1'b0, 1'b1, 3'd3);
        next_cycle();
        drive_entry(64'h99, 64'h5678, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2);
        next_cycle();
        drive_idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_alu_result, out_store_data, out_rd, out_reg_write,
             out_mem_read, out_mem_write, out_funct3, fwd_valid, fwd_rd, fwd_data}
            !== {1'b0, 1'b1, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b ready=%b res=%h sd=%h rd=%0d f3=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, out_alu_result, out_store_data, out_rd, out_funct3);
        end
        out_ready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stale: got valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_store_data = 64'd0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_funct3     = 3'd0;
        drive_idle();
        test_reset();
        test_basic();
        test_stream();
        test_skid();
        test_rd_zero();
        test_load_store();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
